// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: default 640x480@60 constants, a per-axis mode record,
// and the total-length helper used by every axis counter.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } mode_t;

  localparam mode_t Mode640x480H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam mode_t Mode640x480V = '{active: 480, fp: 10, sync: 2, bp: 33};
  localparam int unsigned DefaultCw = 10;

  function automatic int unsigned total_len(input mode_t m);
    return m.active + m.fp + m.sync + m.bp;
  endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: a wrapping counter over active/fp/sync/bp with decoded active and
// sync flags. sync_asserted_o is driven at the configured polarity.
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CW     = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          advance_i,
  output logic [CW-1:0] count_o,
  output logic          wrap_o,
  output logic          active_o,
  output logic          sync_asserted_o
);

  localparam mode_t       Mode  = '{active: ACTIVE, fp: FP, sync: SYNC, bp: BP};
  localparam int unsigned Total = total_len(Mode);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1 ||
      longint'(Total) > (longint'(1) << CW)) begin : g_bad_params
    $fatal(1, "timing_axis: every length must be >= 1 and the total must fit in CW bits");
  end

  localparam logic [CW-1:0] Last      = CW'(Total - 1);
  localparam logic [CW-1:0] ActiveEnd = CW'(ACTIVE);
  localparam logic [CW-1:0] SyncStart = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SyncEnd   = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] count_q, count_d;
  logic          in_sync;

  assign wrap_o   = (count_q == Last);
  assign active_o = (count_q < ActiveEnd);
  assign in_sync  = (count_q >= SyncStart) && (count_q < SyncEnd);

  assign sync_asserted_o = in_sync ? POL : ~POL;
  assign count_o         = count_q;

  always_comb begin
    count_d = count_q;
    if (advance_i) begin
      count_d = wrap_o ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: two axis counters plus a registered output stage that
// presents the decode of the pre-edge counts one enabled cycle later.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = Mode640x480H.active,
  parameter int unsigned H_FP      = Mode640x480H.fp,
  parameter int unsigned H_SYNC    = Mode640x480H.sync,
  parameter int unsigned H_BP      = Mode640x480H.bp,
  parameter int unsigned V_ACTIVE  = Mode640x480V.active,
  parameter int unsigned V_FP      = Mode640x480V.fp,
  parameter int unsigned V_SYNC    = Mode640x480V.sync,
  parameter int unsigned V_BP      = Mode640x480V.bp,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CW        = DefaultCw
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          En,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  logic [CW-1:0] h_count, v_count;
  logic          h_wrap, v_wrap, h_active, v_active, h_sync, v_sync;
  logic          unused_v_wrap;

  // The frame wrap is implied by the counts themselves; nothing downstream needs it.
  assign unused_v_wrap = v_wrap;

  timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL),
    .CW     (CW)
  ) u_h_axis (
    .clk_i           (Clk),
    .rst_i           (Rst),
    .advance_i       (En),
    .count_o         (h_count),
    .wrap_o          (h_wrap),
    .active_o        (h_active),
    .sync_asserted_o (h_sync)
  );

  timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL),
    .CW     (CW)
  ) u_v_axis (
    .clk_i           (Clk),
    .rst_i           (Rst),
    .advance_i       (En && h_wrap),
    .count_o         (v_count),
    .wrap_o          (v_wrap),
    .active_o        (v_active),
    .sync_asserted_o (v_sync)
  );

  logic          hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
  logic [CW-1:0] x_q, y_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
    end else if (En) begin
      hsync_q       <= h_sync;
      vsync_q       <= v_sync;
      de_q          <= h_active && v_active;
      line_start_q  <= (h_count == '0);
      frame_start_q <= (h_count == '0) && (v_count == '0);
      x_q           <= h_count;
      y_q           <= v_count;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign x           = x_q;
  assign y           = y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: two small-mode instances (active-low and active-high sync) against
// a pixel-index reference model, with directed and randomized enable/reset stimulus.
module tb_vga_timing_gen;

  // Instance A: the small mode 4/1/2/1 x 3/1/1/1, active-low syncs.
  localparam int AHA = 4, AHF = 1, AHS = 2, AHB = 1;
  localparam int AVA = 3, AVF = 1, AVS = 1, AVB = 1;
  // Instance B: odd-sized mode with active-high syncs.
  localparam int BHA = 10, BHF = 3, BHS = 4, BHB = 2;
  localparam int BVA = 6, BVF = 2, BVS = 3, BVB = 2;

  localparam int AHT = AHA + AHF + AHS + AHB;  // 8
  localparam int AVT = AVA + AVF + AVS + AVB;  // 6
  localparam int BHT = BHA + BHF + BHS + BHB;  // 19
  localparam int BVT = BVA + BVF + BVS + BVB;  // 13

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic En  = 1'b0;

  logic       hsync_a, vsync_a, de_a, ls_a, fs_a;
  logic [3:0] x_a, y_a;
  logic       hsync_b, vsync_b, de_b, ls_b, fs_b;
  logic [4:0] x_b, y_b;

  int checks   = 0;
  int failures = 0;

  int          pa = 0, pb = 0;
  logic [20:0] ea, eb;

  always #5 Clk = ~Clk;

  vga_timing_gen #(
    .H_ACTIVE (AHA), .H_FP (AHF), .H_SYNC (AHS), .H_BP (AHB),
    .V_ACTIVE (AVA), .V_FP (AVF), .V_SYNC (AVS), .V_BP (AVB),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0), .CW (4)
  ) u_dut_a (
    .Clk (Clk), .Rst (Rst), .En (En),
    .hsync (hsync_a), .vsync (vsync_a), .de (de_a), .x (x_a), .y (y_a),
    .line_start (ls_a), .frame_start (fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (BHA), .H_FP (BHF), .H_SYNC (BHS), .H_BP (BHB),
    .V_ACTIVE (BVA), .V_FP (BVF), .V_SYNC (BVS), .V_BP (BVB),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b1), .CW (5)
  ) u_dut_b (
    .Clk (Clk), .Rst (Rst), .En (En),
    .hsync (hsync_b), .vsync (vsync_b), .de (de_b), .x (x_b), .y (y_b),
    .line_start (ls_b), .frame_start (fs_b)
  );

  // Expected output word for raster position p (pixels since frame start).
  function automatic logic [20:0] expect_at(input int p, input int ha, input int hf,
                                             input int hs, input int hb, input int va,
                                             input int vf, input int vs, input bit hpol,
                                             input bit vpol);
    int  ht, h, v;
    logic hv, vv, dv;
    ht = ha + hf + hs + hb;
    h  = p % ht;
    v  = p / ht;
    hv = (h >= ha + hf && h < ha + hf + hs) ? hpol : !hpol;
    vv = (v >= va + vf && v < va + vf + vs) ? vpol : !vpol;
    dv = (h < ha) && (v < va);
    return {hv, vv, dv, h == 0, (h == 0) && (v == 0), 8'(h), 8'(v)};
  endfunction

  function automatic logic [20:0] reset_word(input bit hpol, input bit vpol);
    return {!hpol, !vpol, 3'b000, 16'h0000};
  endfunction

  // One clock edge with the given inputs, then the model update and comparison.
  task automatic step(input logic rst, input logic en);
    logic [20:0] oa, ob;
    Rst = rst;
    En  = en;
    @(posedge Clk);
    if (rst) begin
      ea = reset_word(1'b0, 1'b0);
      eb = reset_word(1'b1, 1'b1);
      pa = 0;
      pb = 0;
    end else if (en) begin
      ea = expect_at(pa, AHA, AHF, AHS, AHB, AVA, AVF, AVS, 1'b0, 1'b0);
      eb = expect_at(pb, BHA, BHF, BHS, BHB, BVA, BVF, BVS, 1'b1, 1'b1);
      pa = (pa + 1) % (AHT * AVT);
      pb = (pb + 1) % (BHT * BVT);
    end
    #1;
    oa = {hsync_a, vsync_a, de_a, ls_a, fs_a, 8'(x_a), 8'(y_a)};
    ob = {hsync_b, vsync_b, de_b, ls_b, fs_b, 8'(x_b), 8'(y_b)};
    checks++;
    assert (oa === ea) else begin
      failures++;
      $error("FAIL inst_a obs=%h exp=%h (hs,vs,de,ls,fs,x,y)", oa, ea);
    end
    checks++;
    assert (ob === eb) else begin
      failures++;
      $error("FAIL inst_b obs=%h exp=%h (hs,vs,de,ls,fs,x,y)", ob, eb);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int de_cnt_a, ls_cnt_a, fs_cnt_a, hs_low_a;
    int de_cnt_b, hs_hi_b, vs_hi_b, fs_cnt_b;
    int wrap_same_edge;

    // Reset held with En = 1: outputs sit at reset values.
    ea = '0;
    eb = '0;
    @(negedge Clk);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // First enabled edge after release gives (0,0) with de and both strobes.
    step(1'b0, 1'b1);
    check_int("first_x_a", int'(x_a), 0);
    check_int("first_y_a", int'(y_a), 0);
    check_int("first_de_fs_ls_a", int'({de_a, fs_a, ls_a}), 7);

    // Full frames with En held high: per-frame counts derived from the mode lengths.
    de_cnt_a = int'(de_a); ls_cnt_a = int'(ls_a); fs_cnt_a = int'(fs_a);
    hs_low_a = int'(!hsync_a);
    de_cnt_b = int'(de_b); hs_hi_b = int'(hsync_b); vs_hi_b = int'(vsync_b);
    fs_cnt_b = int'(fs_b);
    wrap_same_edge = 0;
    for (int i = 1; i < BHT * BVT; i++) begin
      step(1'b0, 1'b1);
      if (i < AHT * AVT) begin
        de_cnt_a += int'(de_a); ls_cnt_a += int'(ls_a); fs_cnt_a += int'(fs_a);
        hs_low_a += int'(!hsync_a);
      end
      if (i == AHT * AVT) begin
        wrap_same_edge = int'(x_a == 4'd0 && y_a == 4'd0 && fs_a);
      end
      de_cnt_b += int'(de_b); hs_hi_b += int'(hsync_b); vs_hi_b += int'(vsync_b);
      fs_cnt_b += int'(fs_b);
    end
    check_int("frame_de_a", de_cnt_a, AHA * AVA);
    check_int("frame_ls_a", ls_cnt_a, AVT);
    check_int("frame_fs_a", fs_cnt_a, 1);
    check_int("frame_hsync_low_a", hs_low_a, AHS * AVT);
    check_int("xy_wrap_same_edge_a", wrap_same_edge, 1);
    check_int("frame_de_b", de_cnt_b, BHA * BVA);
    check_int("frame_hsync_high_b", hs_hi_b, BHS * BVT);
    check_int("frame_vsync_high_b", vs_hi_b, BVS * BHT);
    check_int("frame_fs_b", fs_cnt_b, 1);

    // En toggling every cycle: outputs hold on the disabled edges.
    for (int i = 0; i < 60; i++) begin
      step(1'b0, (i % 2) == 0);
    end

    // Mid-frame reset with En low still takes effect; restart at (0,0).
    for (int i = 0; i < 23; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check_int("restart_fs_b", int'({fs_b, x_b, y_b}), 32'h400);

    // Randomized enable and occasional reset against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
